// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the rv32i core.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB, handshakes with
// variable-latency instruction and data memories, strobes the PC and the
// register file once per instruction, and supports halt, memory timeout
// detection and free-running performance counters.
module multicycle_sequencer #(
    parameter int WORD_SIZE  = 32,
    parameter int MAX_WAIT   = 15,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic [WORD_SIZE-1:0]  imem_rdata,
    output logic [WORD_SIZE-1:0]  instr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_write_req,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  rf_we,
    output logic                  retire,
    input  logic                  halt,
    output logic                  halted,
    output logic                  timeout_err,
    output logic [PERF_CNT_W-1:0] cycle_count,
    output logic [PERF_CNT_W-1:0] instret_count
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    state_t                  state_q;
    logic [WAIT_W-1:0]       wait_cnt_q;
    logic [WORD_SIZE-1:0]    instr_q;
    logic                    imem_req_q;
    logic                    dmem_req_q;
    logic                    dmem_we_q;
    logic                    pc_en_q;
    logic                    rf_we_q;
    logic                    retire_q;
    logic                    halted_q;
    logic                    timeout_err_q;
    logic [PERF_CNT_W-1:0]   cycle_count_q;
    logic [PERF_CNT_W-1:0]   instret_count_q;

    // Sequencer FSM; every output is registered as a function of the state being entered.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside
        // the clocked branch rather than in the sensitivity list.
        if (!reset) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= '0;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            pc_en_q       <= 1'b0;
            rf_we_q       <= 1'b0;
            retire_q      <= 1'b0;
            halted_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; these defaults make the WB
            // strobes last exactly one cycle unless a branch below re-arms them.
            pc_en_q  <= 1'b0;
            rf_we_q  <= 1'b0;
            retire_q <= 1'b0;

            unique case (state_q)
                S_FETCH: begin
                    if (!imem_req_q) begin
                        // First cycle after reset release: raise the fetch request.
                        imem_req_q <= 1'b1;
                    end else if (imem_ready) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= S_DECODE;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        imem_req_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        wait_cnt_q    <= '0;
                        state_q       <= S_ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end

                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end

                S_EXECUTE: begin
                    if (mem_read || mem_write) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= mem_write;  // store wins when both are decoded
                        state_q    <= S_MEM;
                    end else begin
                        pc_en_q  <= 1'b1;
                        retire_q <= 1'b1;
                        rf_we_q  <= reg_write_req;
                        state_q  <= S_WB;
                    end
                end

                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        wait_cnt_q <= '0;
                        pc_en_q    <= 1'b1;
                        retire_q   <= 1'b1;
                        rf_we_q    <= reg_write_req;
                        state_q    <= S_WB;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        dmem_req_q    <= 1'b0;
                        dmem_we_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        wait_cnt_q    <= '0;
                        state_q       <= S_ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end

                S_WB: begin
                    if (halt) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end

                S_HALT: begin
                    if (!halt) begin
                        halted_q   <= 1'b0;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end

                S_ERR: begin
                    // Only reset leaves the error state.
                    state_q <= S_ERR;
                end

                default: begin
                    imem_req_q    <= 1'b0;
                    dmem_req_q    <= 1'b0;
                    dmem_we_q     <= 1'b0;
                    timeout_err_q <= 1'b1;
                    state_q       <= S_ERR;
                end
            endcase
        end
    end

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_q + PERF_CNT_W'(1);
            if (state_q == S_WB) begin
                instret_count_q <= instret_count_q + PERF_CNT_W'(1);
            end
        end
    end

    assign imem_req      = imem_req_q;
    assign instr         = instr_q;
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign pc_en         = pc_en_q;
    assign rf_we         = rf_we_q;
    assign retire        = retire_q;
    assign halted        = halted_q;
    assign timeout_err   = timeout_err_q;
    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer.
// Each instruction is described at transaction level (fetch waits, memory kind,
// data waits, halt length); a generator expands it into a per-cycle timeline of
// inputs and expected outputs, which a single compare process checks every cycle.
module tb_multicycle_sequencer;

    localparam int WS = 32;
    localparam int MW = 15;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_ready = 1'b0;
    logic [WS-1:0] imem_rdata = '0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic          reg_write_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          halt = 1'b0;

    logic          imem_req;
    logic [WS-1:0] instr;
    logic          dmem_req;
    logic          dmem_we;
    logic          pc_en;
    logic          rf_we;
    logic          retire;
    logic          halted;
    logic          timeout_err;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instret_count;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .WORD_SIZE (WS),
        .MAX_WAIT  (MW),
        .PERF_CNT_W(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write_req(reg_write_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .rf_we        (rf_we),
        .retire       (retire),
        .halt         (halt),
        .halted       (halted),
        .timeout_err  (timeout_err),
        .cycle_count  (cycle_count),
        .instret_count(instret_count)
    );

    // One cycle of the timeline: inputs to drive and outputs expected.
    typedef struct {
        bit            chk;
        logic          rst_n, rdy_i, mr, mw, rwr, rdy_d, hlt;
        logic [WS-1:0] rdata;
        logic          ireq, dreq, dwe, pc, rf, ret, hltd, terr;
        logic [WS-1:0] ins;
        logic [CW-1:0] cyc, iret;
    } step_t;

    step_t         exp_s;
    bit            exp_valid = 1'b0;
    int            total = 0;
    int            bad = 0;

    // Model state carried between cycles.
    logic [CW-1:0] m_cyc = '0;
    logic [CW-1:0] m_iret = '0;
    logic [WS-1:0] m_instr = '0;
    int            budget = -1;
    logic          idle_rdy = 1'b0;

    // Observations of DUT activity for the hand-computed checks.
    int            ret_cycles[$];
    int            n_ireq, n_dreq, n_dwe, n_hltd;

    task automatic check1(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic step_t base(input logic mr, input logic mw, input logic rwr);
        step_t s;
        s.chk   = 1'b1;
        s.rst_n = 1'b1;
        s.rdy_i = idle_rdy;
        s.rdy_d = idle_rdy;
        s.mr    = mr;
        s.mw    = mw;
        s.rwr   = rwr;
        s.hlt   = 1'b0;
        s.rdata = 32'hFFFF_FFFF;
        s.ireq  = 1'b0;
        s.dreq  = 1'b0;
        s.dwe   = 1'b0;
        s.pc    = 1'b0;
        s.rf    = 1'b0;
        s.ret   = 1'b0;
        s.hltd  = 1'b0;
        s.terr  = 1'b0;
        s.ins   = '0;
        s.cyc   = '0;
        s.iret  = '0;
        return s;
    endfunction

    // Play one cycle: drive inputs, publish expectations, advance the model.
    task automatic emit(input step_t st);
        step_t s;
        s = st;
        if (budget == 0) return;
        if (budget > 0) budget--;
        s.ins  = m_instr;
        s.cyc  = m_cyc;
        s.iret = m_iret;
        @(posedge clk);
        #1;
        reset         = s.rst_n;
        imem_ready    = s.rdy_i;
        imem_rdata    = s.rdata;
        mem_read      = s.mr;
        mem_write     = s.mw;
        reg_write_req = s.rwr;
        dmem_ready    = s.rdy_d;
        halt          = s.hlt;
        exp_s         = s;
        exp_valid     = 1'b1;
        if (!s.rst_n) begin
            m_cyc   = '0;
            m_iret  = '0;
            m_instr = '0;
        end else begin
            m_cyc = m_cyc + CW'(1);
            if (s.ret) m_iret = m_iret + CW'(1);
            if (s.ireq && s.rdy_i) m_instr = s.rdata;
        end
    endtask

    // n reset cycles, then the release cycle in which everything is still quiet.
    task automatic gen_reset(input int n);
        step_t s;
        s = base(1'b0, 1'b0, 1'b0);
        s.rst_n = 1'b0;
        s.chk   = 1'b0;  // outputs here still reflect whatever came before
        emit(s);
        s.chk = 1'b1;
        for (int k = 1; k < n; k++) emit(s);
        emit(base(1'b0, 1'b0, 1'b0));
    endtask

    // One instruction: w fetch waits, optional memory phase with d waits,
    // and h cycles of HALT after write-back when h > 0.
    task automatic gen_instr(input int w, input logic [WS-1:0] word, input logic mr,
                             input logic mw, input logic rwr, input int d, input int h);
        step_t s;
        for (int k = 0; k <= w; k++) begin
            s = base(mr, mw, rwr);
            s.ireq  = 1'b1;
            s.rdy_i = (k == w);
            s.rdata = (k == w) ? word : ~word;
            emit(s);
        end
        emit(base(mr, mw, rwr));
        s = base(mr, mw, rwr);
        s.hlt = (h > 0);
        emit(s);
        if (mr || mw) begin
            for (int k = 0; k <= d; k++) begin
                s = base(mr, mw, rwr);
                s.hlt   = (h > 0);
                s.dreq  = 1'b1;
                s.dwe   = mw;
                s.rdy_d = (k == d);
                emit(s);
            end
        end
        s = base(mr, mw, rwr);
        s.hlt = (h > 0);
        s.pc  = 1'b1;
        s.ret = 1'b1;
        s.rf  = rwr;
        emit(s);
        for (int k = 1; k <= h; k++) begin
            s = base(1'b0, 1'b0, 1'b0);
            s.hlt  = (k < h);
            s.hltd = 1'b1;
            emit(s);
        end
    endtask

    // Fetch cycles that see no ready (n must stay within the timeout window).
    task automatic gen_idle_fetch(input int n);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s = base(1'b0, 1'b0, 1'b0);
            s.ireq  = 1'b1;
            s.rdy_i = 1'b0;
            emit(s);
        end
    endtask

    // Fetch that never completes, followed by n_err cycles in the error state.
    task automatic gen_timeout(input int n_err);
        step_t s;
        gen_idle_fetch(MW + 1);
        for (int k = 0; k < n_err; k++) begin
            s = base(1'b0, 1'b0, 1'b0);
            s.terr  = 1'b1;
            s.rdy_i = 1'b1;
            s.rdy_d = 1'b1;
            emit(s);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        ret_cycles.delete();
        n_ireq = 0;
        n_dreq = 0;
        n_dwe  = 0;
        n_hltd = 0;
    endtask

    function automatic int ret_at(input int i);
        return (i < ret_cycles.size()) ? ret_cycles[i] : -1;
    endfunction

    // Compare every DUT output against the timeline, mid-cycle.
    always @(negedge clk) begin
        if (exp_valid && exp_s.chk) begin
            check1 ("imem_req",      imem_req,      exp_s.ireq);
            check32("instr",         instr,         exp_s.ins);
            check1 ("dmem_req",      dmem_req,      exp_s.dreq);
            check1 ("dmem_we",       dmem_we,       exp_s.dwe);
            check1 ("pc_en",         pc_en,         exp_s.pc);
            check1 ("rf_we",         rf_we,         exp_s.rf);
            check1 ("retire",        retire,        exp_s.ret);
            check1 ("halted",        halted,        exp_s.hltd);
            check1 ("timeout_err",   timeout_err,   exp_s.terr);
            check32("cycle_count",   32'(cycle_count),   32'(exp_s.cyc));
            check32("instret_count", 32'(instret_count), 32'(exp_s.iret));
            if (retire) ret_cycles.push_back(int'(cycle_count));
            n_ireq += int'(imem_req);
            n_dreq += int'(dmem_req);
            n_dwe  += int'(dmem_we);
            n_hltd += int'(halted);
        end
    end

    initial begin
        int exp_r[3];
        exp_r = '{4, 8, 12};

        // 1: zero-wait ALU stream, ready held high throughout.
        idle_rdy = 1'b1;
        clear_obs();
        gen_reset(2);
        for (int i = 0; i < 3; i++) begin
            gen_instr(0, 32'h0010_0093 + 32'(i << 7), 1'b0, 1'b0, 1'b1, 0, 0);
        end
        gen_idle_fetch(1);
        sync();
        check32("t1_retire_count", 32'(ret_cycles.size()), 32'd3);
        for (int i = 0; i < 3; i++) check32("t1_retire_cycle", 32'(ret_at(i)), 32'(exp_r[i]));
        check32("t1_instret", 32'(instret_count), 32'd3);
        check32("t1_instr", instr, 32'h0010_0193);

        // 2: load with two data waits, then a store whose fetch ready lands on the last allowed wait.
        idle_rdy = 1'b0;
        clear_obs();
        gen_reset(1);
        gen_instr(0, 32'h0000_2103, 1'b1, 1'b0, 1'b1, 2, 0);
        sync();
        check32("t2_retire_cycle", 32'(ret_at(0)), 32'd7);
        check32("t2_dmem_req_cycles", 32'(n_dreq), 32'd3);
        check32("t2_dmem_we_cycles", 32'(n_dwe), 32'd0);
        gen_instr(MW, 32'h0020_2023, 1'b0, 1'b1, 1'b0, 0, 0);
        gen_idle_fetch(1);
        sync();
        check1 ("t2_no_timeout", timeout_err, 1'b0);
        check32("t2_instret", 32'(instret_count), 32'd2);
        check32("t2_dmem_we_cycles", 32'(n_dwe), 32'd1);

        // 3: instruction memory never answers.
        clear_obs();
        gen_reset(1);
        gen_timeout(5);
        sync();
        check32("t3_imem_req_cycles", 32'(n_ireq), 32'd16);
        check1 ("t3_timeout_err", timeout_err, 1'b1);
        check1 ("t3_imem_req", imem_req, 1'b0);

        // 4: halt raised in EXECUTE, three HALT cycles, then restart.
        idle_rdy = 1'b1;
        clear_obs();
        gen_reset(1);
        gen_instr(0, 32'h0030_0213, 1'b0, 1'b0, 1'b1, 0, 3);
        gen_instr(1, 32'h0040_0293, 1'b0, 1'b0, 1'b0, 0, 0);
        sync();
        check32("t4_halted_cycles", 32'(n_hltd), 32'd3);
        check32("t4_retire0", 32'(ret_at(0)), 32'd4);
        check32("t4_retire1", 32'(ret_at(1)), 32'd12);

        // 5: reset lands while a store is waiting in MEM.
        idle_rdy = 1'b0;
        clear_obs();
        gen_reset(1);
        budget = 5;
        gen_instr(0, 32'h0050_2023, 1'b0, 1'b1, 1'b1, 6, 0);
        budget = -1;
        sync();
        check1 ("t5_in_mem", dmem_req, 1'b1);
        check32("t5_no_retire", 32'(ret_cycles.size()), 32'd0);
        gen_reset(1);
        gen_instr(0, 32'h0060_0313, 1'b0, 1'b0, 1'b1, 0, 0);
        gen_idle_fetch(1);
        sync();
        check32("t5_retire_cycle", 32'(ret_at(0)), 32'd4);
        check32("t5_instret", 32'(instret_count), 32'd1);

        // 6: load+store decode (store wins) and 4-bit counter wrap after 20 cycles.
        idle_rdy = 1'b1;
        clear_obs();
        gen_reset(1);
        gen_instr(0, 32'h0070_2023, 1'b1, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) gen_instr(0, 32'h0080_0393, 1'b0, 1'b0, 1'b1, 0, 0);
        budget = 3;
        gen_instr(0, 32'h0090_0413, 1'b0, 1'b0, 1'b1, 0, 0);
        budget = -1;
        sync();
        check32("t6_cycle_wrap", 32'(cycle_count), 32'd4);
        check32("t6_dmem_we_cycles", 32'(n_dwe), 32'd1);
        check32("t6_instret", 32'(instret_count), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
